// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: W-bit add/subtract computed one 4-bit carry-lookahead nibble per clock,
// least significant nibble first, with a valid/ready handshake on both sides.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 cin,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] F,
    output logic                 cout,
    output logic                 ovf
);
    localparam int W  = 4*NIBBLES;
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_n;
    logic [W-1:0]    a_r, b_r;
    logic            carry;
    logic [IW-1:0]   idx;
    logic [3:0]      an, bn, g, p, s;
    logic [4:0]      c;
    logic            last;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign an        = a_r[idx*4 +: 4];
    assign bn        = b_r[idx*4 +: 4];
    assign last      = idx == IW'(NIBBLES-1);

    always_comb begin
        g    = an & bn;
        p    = an | bn;
        c[0] = carry;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s    = an ^ bn ^ c[3:0];
    end

    always_comb begin
        state_n = state == IDLE ? (in_valid  ? RUN  : IDLE) :
                  state == RUN  ? (last      ? DONE : RUN)  :
                                  (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Subtraction is A + ~B + 1, so B is inverted at capture and the carry seeded with 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            F     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
        end else if (state == IDLE && in_valid) begin
            a_r   <= A;
            b_r   <= B ^ {W{sub}};
            carry <= sub | cin;
            idx   <= '0;
        end else if (state == RUN) begin
            F[idx*4 +: 4] <= s;
            carry         <= c[4];
            idx           <= last ? '0 : idx + 1'b1;
            if (last) begin
                cout <= c[4];
                ovf  <= c[3] ^ c[4];
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and randomised checks of the serial adder with NIBBLES=4.
module tb_nibble_serial_adder;
    localparam int N = 4;
    localparam int W = 4*N;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] A, B, F;
    int           tests = 0, fails = 0, accepts = 0, outs = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .F(F), .cout(cout), .ovf(ovf)
    );

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready)   accepts++;
        if (!rst && out_valid && out_ready) outs++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width arithmetic, borrow-based for subtraction.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, b, input logic ci, s);
        logic [W:0] r;
        logic       co, ov;
        if (s) begin
            r  = {1'b0, a} - {1'b0, b};
            co = ~r[W];
            ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            r  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            co = r[W];
            ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
        return {ov, co, r[W-1:0]};
    endfunction

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, b, input logic ci, s, input bit rr,
                          output logic [W-1:0] f, output logic co, ov, output int lat);
        int k;
        @(negedge clk);
        A = a; B = b; cin = ci; sub = s; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        f = F; co = cout; ov = ovf;
        k = 0;
        out_ready = rr ? ($urandom_range(0, 2) == 0) : 1'b1;
        while (!out_ready) begin
            @(negedge clk);
            check("hold_F", F, f);
            k++;
            out_ready = (k >= 8) || ($urandom_range(0, 2) == 0);
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic dir(input string tag, input logic [W-1:0] a, b, input logic ci, s,
                       input logic [W-1:0] ef, input logic ec, eo);
        logic [W-1:0] f;
        logic         co, ov;
        int           lat;
        run_op(a, b, ci, s, 1'b0, f, co, ov, lat);
        check({tag, "_F"}, f, ef);
        check({tag, "_cout"}, co, ec);
        check({tag, "_ovf"}, ov, eo);
        check({tag, "_lat"}, lat, N);
    endtask

    initial begin
        logic [W-1:0] f, ra, rb;
        logic         co, ov, rc, rs;
        logic [W+1:0] m;
        int           lat, a0, o0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_F", F, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);

        dir("add_5555", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        dir("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        dir("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        dir("add_cin", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        dir("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        dir("sub_neg_cin", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        dir("sub_ovf_cin", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        dir("sub_zero", 16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Backpressure: new operands offered while the result is held.
        @(negedge clk);
        A = 16'h1111; B = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_lat", lat, N);
        A = 16'hAAAA; B = 16'h1111; in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_F", F, 16'h3333);
            check("bp_cout", cout, 0);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_in_ready", in_ready, 1);
        check("bp_idle_out_valid", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accept", in_ready, 0);
        wait_valid(lat);
        check("bp2_lat", lat, N);
        check("bp2_F", F, 16'hBBBB);
        check("bp2_cout", cout, 0);
        check("bp2_ovf", ovf, 0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset two RUN edges into an operation.
        A = 16'hFFFF; B = 16'h0001; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_F", F, 0);
        check("mid_rst_cout", cout, 0);
        repeat (6) @(negedge clk);
        check("mid_rst_no_stale", out_valid, 0);
        dir("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Reset wins over a DONE handshake on the same edge.
        A = 16'h7FFF; B = 16'h0001; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        check("done_rst_lat", lat, N);
        rst = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0;
        check("done_rst_F", F, 0);
        check("done_rst_ovf", ovf, 0);
        check("done_rst_out_valid", out_valid, 0);

        a0 = accepts; o0 = outs;
        for (int i = 0; i < 10000; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            if (i % 8 == 0) rb = (i % 16 == 0) ? 16'h0001 : 16'hFFFF;
            m = model(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs, 1'b1, f, co, ov, lat);
            check("rnd_lat", lat, N);
            check("rnd_res", {ov, co, f}, m);
        end
        @(negedge clk);
        check("accept_vs_out", accepts - a0, outs - o0);
        check("accept_count", accepts - a0, 10000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter: NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 in_valid  input  1  operand set offered.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 A  input  W  operand A.
REQ-007 B  input  W  operand B.
REQ-008 cin  input  1  carry-in; add mode only.
REQ-009 sub  input  1  0 = A+B+cin; 1 = A-B.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 F  output  W  sum/difference.
REQ-013 cout  output  1  carry-out of MSB slice; for sub, 1 = no borrow.
REQ-014 ovf  output  1  two's-complement overflow.

Function
REQ-015 The block SHALL compute a W-bit add/subtract one nibble per clock, least significant nibble first, through one 4-bit carry-lookahead slice (generate g=a&b, propagate p=a|b, full lookahead to c4).
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IDLE: in_ready=1, out_valid=0; on an edge with in_valid=1, the block SHALL register A, B^{W{sub}}, the initial carry (sub ? 1 : cin) and the op, clear the nibble index to 0, and go to RUN.
REQ-018 RUN: in_ready=0, out_valid=0; each edge adds nibble[idx] plus the carry register, writes F nibble idx, stores c4 into the carry register, and increments idx.
REQ-019 On the edge processing idx=NIBBLES-1, the block SHALL latch cout=c4 and ovf=(carry into bit W-1) XOR c4, then go to DONE.
REQ-020 Latency SHALL be exactly NIBBLES edges from the accepting edge to the edge after which out_valid=1.
REQ-021 DONE: out_valid=1, in_ready=0; F, cout and ovf SHALL stay stable until the handshake; the block returns to IDLE on an edge with out_ready=1.
REQ-022 in_valid SHALL be ignored outside IDLE; there is no accept on the same edge as the DONE handshake; peak throughput is one op per NIBBLES+2 cycles.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 Nibble index and carry SHALL wrap cleanly: no carry propagates from one operation into the next.
REQ-025 in_ready and out_valid SHALL be decoded from state only, with no combinational path from inputs.

Reset
REQ-026 On an edge with rst=1, the FSM SHALL go to IDLE and set F=0, cout=0, ovf=0, out_valid=0, idx=0 and carry=0; in_ready=1 from the next cycle.
REQ-027 rst SHALL take priority over every other event, including mid-RUN and a DONE handshake on the same edge; the in-flight operation is discarded and never presented.

Verification (NIBBLES=4)
REQ-028 Add 0x1234+0x4321, cin=0 -> F=0x5555, cout=0, ovf=0; out_valid rises 4 edges after the accept.
REQ-029 Add 0xFFFF+0x0001, cin=0 -> F=0x0000, cout=1, ovf=0 (carry ripples through all 4 slices); then 0x7FFF+0x0001 -> F=0x8000, cout=0, ovf=1.
REQ-030 Sub 0x0005-0x0007 -> F=0xFFFE, cout=0, ovf=0; sub 0x8000-0x0001 -> F=0x7FFF, cout=1, ovf=1; cin=1 during sub has no effect.
REQ-031 Backpressure: out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands -> F/cout/ovf stable, in_ready=0, new operands not taken; after the handshake, the next op is accepted in IDLE and computes correctly.
REQ-032 rst pulsed after 2 RUN edges of 0xFFFF+0x0001 -> IDLE, out_valid=0, F=0 the next cycle, no stale result; a following 0x0001+0x0001 gives F=0x0002, cout=0.
REQ-033 Randomised back-to-back ops (≥10k, random sub/cin, random out_ready) compared against a W+1-bit reference model; out_valid count equals accept count (with no rst).
